// File: rtl/game_pkg.sv
// Shared constants for the round/score controller: state encodings and
// default build parameters.
package game_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PLAY = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_OVER = 2'd3;

    localparam int SCORE_W_DEF     = 4;
    localparam int LIVES_DEF       = 3;
    localparam int HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/game_score_ctrl_if.sv
// Signal bundle between the win/lose stage, the score controller and its
// consumers. master drives the levels, slave is the controller.
interface game_score_ctrl_if #(
    parameter int SCORE_W = game_pkg::SCORE_W_DEF
);
    logic               Start;
    logic               Win;
    logic               Lose;
    logic [SCORE_W-1:0] Score;
    logic [1:0]         Lives;
    logic               RoundReset;
    logic               InRound;
    logic               GameOver;
    logic [SCORE_W-1:0] HighScore;

    modport master (
        output Start, Win, Lose,
        input  Score, Lives, RoundReset, InRound, GameOver, HighScore
    );

    modport slave (
        input  Start, Win, Lose,
        output Score, Lives, RoundReset, InRound, GameOver, HighScore
    );
endinterface

// File: rtl/game_score_ctrl_rise_detect.sv
// Rising-edge detector: one history flop plus AND-NOT. The history flop is
// updated every cycle regardless of controller state, so a level that was
// already high is never reported as an event later.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic evt
);
    logic d_q;

    // History register for the level input.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (Reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign evt = d & ~d_q;
endmodule

// File: rtl/game_score_ctrl.sv
// Round and score controller. Turns Win/Lose levels into round events,
// keeps score and lives, holds each result for HOLD_CYCLES cycles, then
// restarts the round counters with a one-cycle RoundReset or ends the game.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register.
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int LIVES       = LIVES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    game_score_ctrl_if.slave  bus
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               round_reset;
    logic [HC_W-1:0]    hold_cnt;
    logic               hold_done;
    logic               start_evt;
    logic               win_evt;
    logic               lose_evt;

    rise_detect u_start (.Clock(Clock), .Reset(Reset), .d(bus.Start), .evt(start_evt));
    rise_detect u_win   (.Clock(Clock), .Reset(Reset), .d(bus.Win),   .evt(win_evt));
    rise_detect u_lose  (.Clock(Clock), .Reset(Reset), .d(bus.Lose),  .evt(lose_evt));

    assign hold_done = (hold_cnt == HC_W'(HOLD_CYCLES - 1));

    // Game state machine with score, lives, hold timer and RoundReset pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            score       <= '0;
            lives       <= 2'(LIVES);
            round_reset <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            round_reset <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_evt) begin
                        score       <= '0;
                        lives       <= 2'(LIVES);
                        round_reset <= 1'b1;
                        state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A simultaneous win and lose counts as a loss only.
                    if (lose_evt) begin
                        if (lives != 2'd0) lives <= lives - 2'd1;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end else if (win_evt) begin
                        if (score != SCORE_MAX) score <= score + 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        hold_cnt <= '0;
                        if (lives == 2'd0) begin
                            state <= ST_OVER;
                        end else begin
                            state       <= ST_PLAY;
                            round_reset <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score;

    // Capture the best score on the transition into OVER; only Reset clears it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            high_score <= '0;
        end else if (state == ST_HOLD && hold_done && lives == 2'd0 &&
                     score > high_score) begin
            high_score <= score;
        end
    end

    assign bus.HighScore = high_score;
`else
    assign bus.HighScore = '0;
`endif

    assign bus.Score      = score;
    assign bus.Lives      = lives;
    assign bus.RoundReset = round_reset;
    assign bus.InRound    = (state == ST_PLAY);
    assign bus.GameOver   = (state == ST_OVER);
endmodule

// File: tb/tb_game_score_ctrl.sv
// Randomised bench for game_score_ctrl. Two instances share one stimulus
// stream: a default build (SCORE_W=4, LIVES=3, HOLD=4) and a small build
// (SCORE_W=2, LIVES=2, HOLD=1) that reaches score saturation quickly.
// Both are compared every cycle against a per-game behavioural model.
module tb_game_score_ctrl;

    logic Clock;
    logic Reset;
    logic start, win, lose;

    int checks   = 0;
    int failures = 0;

    game_score_ctrl_if #(.SCORE_W(4)) bus_a ();
    game_score_ctrl_if #(.SCORE_W(2)) bus_b ();

    assign bus_a.Start = start;
    assign bus_a.Win   = win;
    assign bus_a.Lose  = lose;
    assign bus_b.Start = start;
    assign bus_b.Win   = win;
    assign bus_b.Lose  = lose;

    game_score_ctrl #(.SCORE_W(4), .LIVES(3), .HOLD_CYCLES(4)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(bus_a)
    );

    game_score_ctrl #(.SCORE_W(2), .LIVES(2), .HOLD_CYCLES(1)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(bus_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: one game per instance.
    typedef enum {M_IDLE, M_PLAY, M_HOLD, M_OVER} mode_e;

    int    cfg_max   [2] = '{15, 3};
    int    cfg_lives [2] = '{3, 2};
    int    cfg_hold  [2] = '{4, 1};

    mode_e m_mode  [2] = '{M_IDLE, M_IDLE};
    int    m_score [2] = '{0, 0};
    int    m_lives [2] = '{3, 2};
    int    m_left  [2] = '{0, 0};
    int    m_best  [2] = '{0, 0};
    bit    m_rr    [2] = '{1'b0, 1'b0};
    bit    prev_start = 1'b0, prev_win = 1'b0, prev_lose = 1'b0;

    always @(posedge Clock) begin
        bit se, we, le;
        se = start && !prev_start;
        we = win   && !prev_win;
        le = lose  && !prev_lose;
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_mode[i]  = M_IDLE;
                m_score[i] = 0;
                m_lives[i] = cfg_lives[i];
                m_left[i]  = 0;
                m_best[i]  = 0;
                m_rr[i]    = 1'b0;
            end else begin
                m_rr[i] = 1'b0;
                case (m_mode[i])
                    M_IDLE, M_OVER: if (se) begin
                        m_score[i] = 0;
                        m_lives[i] = cfg_lives[i];
                        m_rr[i]    = 1'b1;
                        m_mode[i]  = M_PLAY;
                    end
                    M_PLAY: if (le) begin
                        if (m_lives[i] > 0) m_lives[i] = m_lives[i] - 1;
                        m_left[i] = cfg_hold[i];
                        m_mode[i] = M_HOLD;
                    end else if (we) begin
                        if (m_score[i] < cfg_max[i]) m_score[i] = m_score[i] + 1;
                        m_left[i] = cfg_hold[i];
                        m_mode[i] = M_HOLD;
                    end
                    M_HOLD: begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) begin
                            if (m_lives[i] == 0) begin
                                m_mode[i] = M_OVER;
                                if (m_score[i] > m_best[i]) m_best[i] = m_score[i];
                            end else begin
                                m_mode[i] = M_PLAY;
                                m_rr[i]   = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        prev_start = Reset ? 1'b0 : start;
        prev_win   = Reset ? 1'b0 : win;
        prev_lose  = Reset ? 1'b0 : lose;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_best(input int i);
`ifdef HIGH_SCORE_EN
        return m_best[i];
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        check("a_score",      32'(bus_a.Score),      32'(m_score[0]));
        check("a_lives",      32'(bus_a.Lives),      32'(m_lives[0]));
        check("a_roundreset", 32'(bus_a.RoundReset), 32'(m_rr[0]));
        check("a_inround",    32'(bus_a.InRound),    32'(m_mode[0] == M_PLAY));
        check("a_gameover",   32'(bus_a.GameOver),   32'(m_mode[0] == M_OVER));
        check("a_highscore",  32'(bus_a.HighScore),  32'(exp_best(0)));
        check("b_score",      32'(bus_b.Score),      32'(m_score[1]));
        check("b_lives",      32'(bus_b.Lives),      32'(m_lives[1]));
        check("b_roundreset", 32'(bus_b.RoundReset), 32'(m_rr[1]));
        check("b_inround",    32'(bus_b.InRound),    32'(m_mode[1] == M_PLAY));
        check("b_gameover",   32'(bus_b.GameOver),   32'(m_mode[1] == M_OVER));
        check("b_highscore",  32'(bus_b.HighScore),  32'(exp_best(1)));
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        win   = 1'b0;
        lose  = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge Clock);
            compare_all();
            Reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0) win  = ~win;
            if ($urandom_range(0, 3) == 0) lose = ~lose;
            // Occasionally force Win and Lose to rise together.
            if (!win && !lose && $urandom_range(0, 5) == 0) begin
                win  = 1'b1;
                lose = 1'b1;
            end
        end
        @(negedge Clock);
        compare_all();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_score_ctrl.md
# game_score_ctrl

Round and score controller that sits directly downstream of the game's win/lose decision stage. It consumes the Win/Lose levels, converts them to single round events, keeps score and remaining lives, and holds each result briefly. It then issues a one-cycle RoundReset to restart the up/down counters, or ends the game when lives run out.

## Interface
- SCORE_W, 4: score width in bits; score saturates at 2^SCORE_W-1
- LIVES, 3: lives per game; legal range 1..3
- HOLD_CYCLES, 4: cycles spent in HOLD after each result; legal range ≥1
- Reset is synchronous and active-high; the clock is Clock.
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Start  in  1  level; its rising edge starts a game from IDLE or OVER
- Win  in  1  level from the win/lose stage
- Lose  in  1  level from the win/lose stage
- Score  out  SCORE_W  current score
- Lives  out  2  remaining lives
- RoundReset  out  1  one-cycle pulse; drives the counters' Reset
- InRound  out  1  high while in PLAY
- GameOver  out  1  high while in OVER
- HighScore  out  SCORE_W  best score; tied to 0 when feature is compiled out

## Operation
- States: IDLE, PLAY, HOLD, OVER.
- Edge detection:
  - Win_q and Lose_q are registered every cycle in every state.
  - win_evt = Win & ~Win_q; lose_evt = Lose & ~Lose_q.
  - A level already high on entry to PLAY is never counted.
- IDLE:
  - Start rising edge → load Score=0, Lives=LIVES, pulse RoundReset, go to PLAY.
- PLAY:
  - lose_evt → Lives−1, go to HOLD.
  - win_evt (without lose_evt) → Score+1, saturating, go to HOLD.
  - Simultaneous win_evt and lose_evt → treated as Lose only.
- HOLD:
  - Counts HOLD_CYCLES cycles. All Win/Lose edges and Start are ignored.
  - On exit with Lives==0 → OVER, with no RoundReset.
  - On exit with Lives>0 → PLAY, with RoundReset pulse.
- OVER:
  - Score and Lives are frozen.
  - Start rising edge behaves as in IDLE.
- Start edges in PLAY are ignored.
- Reset values, applied the cycle after Reset is sampled:
  - state=IDLE, Score=0, Lives=LIVES, RoundReset=0, InRound=0, GameOver=0, HighScore=0, Win_q=Lose_q=0, hold count=0.
- Reset mid-HOLD or mid-PLAY aborts immediately to IDLE; no RoundReset pulse is emitted.
- Lives never decrements below 0. Score holds at its maximum on further wins.

## Timing
- All outputs are registered.
- Win rising in cycle N: Score is updated and state is HOLD in cycle N+1.
- HOLD occupies cycles N+1 .. N+HOLD_CYCLES.
- Cycle N+HOLD_CYCLES+1: PLAY with RoundReset=1, for exactly one cycle.
- Start rising in cycle N (IDLE/OVER): PLAY with RoundReset=1 in cycle N+1.
- InRound and GameOver are decoded from the state register, so they have no extra latency.

## Configuration
- HIGH_SCORE_EN defined:
  - On entry to OVER, HighScore ← Score if Score > HighScore.
  - Only Reset clears HighScore; Start does not.
- HIGH_SCORE_EN undefined: HighScore is constant 0 and no register is inferred.

## Structure
- Shared package game_pkg holds:
  - state encodings (IDLE=2'd0, PLAY=2'd1, HOLD=2'd2, OVER=2'd3);
  - default SCORE_W, LIVES and HOLD_CYCLES constants.
- One sub-module, rise_detect (1-bit register plus AND-NOT), is instantiated for Start, Win and Lose.

## Test plan
- Reset then Start pulse → PLAY after 1 cycle, RoundReset high for exactly 1 cycle, Score=0, Lives=3.
- Win 0→1 in PLAY (HOLD_CYCLES=4) → Score=1 next cycle, 4 HOLD cycles, then RoundReset pulse. Win held high afterwards → no second increment.
- Three Lose edges → Lives 3→2→1→0. After the third HOLD, GameOver=1 and no RoundReset. A Start edge then gives Score=0, Lives=3, PLAY.
- Win and Lose rising in the same cycle → Lives−1, Score unchanged. Win/Lose edges during HOLD → ignored.
- SCORE_W=2, five wins → Score reaches 3 and stays 3.
- With HIGH_SCORE_EN: game 1 ends at Score 2, game 2 ends at Score 1 → HighScore=2. Reset mid-HOLD → IDLE, HighScore=0, no RoundReset.
